hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Issue/hazard controller for the decode stage and register-file read ports.
//  Keeps a per-register scoreboard of in-flight writes and stalls decode on RAW hazards.
//  Sequences the branch-flush window and counts stall cycles.
//  Sits between decode and execute; its stall/flush outputs drive the decode pipeline register.
// PARAMETERS
//  NUM_REGS      16  architectural registers; address width is 4
//  CNT_W         2   width of each per-register in-flight counter; max count = 2**CNT_W-1
//  FLUSH_CYCLES  2   cycles flush_o stays high after a taken branch (1..7)
// PORTS
//  clk_i          in   1   clock
//  reset_i        in   1   asynchronous, active-low reset
//  dec_valid_i    in   1   decode holds a valid instruction
//  dec_r1_addr_i  in   4   source 1 register address
//  dec_r1_used_i  in   1   source 1 is read by the instruction
//  dec_r2_addr_i  in   4   source 2 register address
//  dec_r2_used_i  in   1   source 2 is read by the instruction
//  dec_rd_addr_i  in   4   destination register address
//  dec_wr_i       in   1   instruction writes rd
//  wb_en_i        in   1   write-back strobe; retires one write to wb_addr_i
//  wb_addr_i      in   4   write-back register address
//  br_taken_i     in   1   one-cycle pulse from execute: branch taken
//  issue_o        out  1   decode instruction moves to execute this cycle (combinational)
//  stall_o        out  1   hold decode and fetch (combinational)
//  flush_o        out  1   kill fetch/decode contents (registered)
//  pending_o      out  16  bit i = cnt[i]!=0
//  stall_cnt_o    out  16  saturating count of stall cycles
//  err_o          out  1   sticky: write-back to a register with cnt==0
// BEHAVIOUR
//  Reset (async, reset_i=0):
//   - All cnt[i]=0; FSM=IDLE; flush_o=0; stall_cnt_o=0; err_o=0.
//   - Hence pending_o=0, issue_o=0, stall_o=0.
//  Scoreboard:
//   - clr_i = wb_en_i & (wb_addr_i==i); eff[i] = cnt[i] - clr_i, computed as 0 if cnt[i]==0.
//  Hazards:
//   - haz = (r1_used & eff[r1]!=0) | (r2_used & eff[r2]!=0) | (dec_wr_i & cnt[rd]==max).
//   - Write-back in the same cycle bypasses the hazard; the register file is write-through.
//  Outputs:
//   - stall_o = dec_valid_i & haz & FSM==IDLE & !br_taken_i.
//   - issue_o = dec_valid_i & !haz & FSM==IDLE & !br_taken_i.
//  Counter update each cycle:
//   - cnt[i] += (issue_o & dec_wr_i & rd==i) - clr_i.
//   - Simultaneous set and clear on the same register: cnt unchanged.
//   - Clear with cnt==0: cnt stays 0 and err_o<=1 (sticky until reset).
//  Branch FSM:
//   - IDLE: br_taken_i -> FLUSH, fcnt=FLUSH_CYCLES-1, flush_o<=1.
//   - FLUSH: flush_o=1; fcnt==0 -> IDLE, flush_o<=0; otherwise fcnt--.
//   - br_taken_i while in FLUSH: fcnt reloads to FLUSH_CYCLES-1 (window extends).
//   - No issue occurs during br_taken_i or FLUSH, so wrong-path instructions never touch the scoreboard.
//   - Write-backs still clear counters during FLUSH.
//  Stall counter:
//   - stall_cnt_o increments on every stall_o cycle; holds at 16'hFFFF.
//  Reset mid-flush or mid-hazard: everything returns immediately to reset values.
// TESTING
//  1. Issue wr r3, next instr reads r3 with no wb -> stall_o=1 each cycle, issue_o=0.
//     wb_en_i=1, wb_addr_i=3 -> same cycle issue_o=1, stall_o=0, pending_o[3] drops to 0.
//  2. Three back-to-back issues writing r5 -> cnt[5]=3.
//     Fourth writer of r5 -> stall_o=1 until a wb to r5; cnt[5] ends at 3, not 4.
//  3. Issue wr r2 with wb_en_i to r2 in the same cycle (cnt[2]=1) -> cnt[2] stays 1.
//  4. br_taken_i at cycle T (FLUSH_CYCLES=2) -> issue_o=0 at T; flush_o=1 at T+1 and T+2; 0 at T+3.
//     Second pulse at T+1 -> flush_o high through T+3.
//  5. wb_en_i to r7 with cnt[7]=0 -> err_o=1 and stays 1; cnt[7]=0; later hazards unaffected.
//  6. Hold a stall for 70000 cycles -> stall_cnt_o=16'hFFFF.
//     Drop reset_i mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the decode, write-back and branch signals that the hazard
//   controller consumes, and the issue/stall/flush/status signals it returns.
//   master : decode/execute side (drives dec_*, wb_*, br_taken_i)
//   slave  : hazard controller (drives issue_o, stall_o, flush_o, pending_o,
//            stall_cnt_o, err_o)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int NUM_REGS = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic                dec_valid_i;
    logic [AW-1:0]       dec_r1_addr_i;
    logic                dec_r1_used_i;
    logic [AW-1:0]       dec_r2_addr_i;
    logic                dec_r2_used_i;
    logic [AW-1:0]       dec_rd_addr_i;
    logic                dec_wr_i;
    logic                wb_en_i;
    logic [AW-1:0]       wb_addr_i;
    logic                br_taken_i;

    logic                issue_o;
    logic                stall_o;
    logic                flush_o;
    logic [NUM_REGS-1:0] pending_o;
    logic [15:0]         stall_cnt_o;
    logic                err_o;

    modport master (
        output dec_valid_i, dec_r1_addr_i, dec_r1_used_i, dec_r2_addr_i,
               dec_r2_used_i, dec_rd_addr_i, dec_wr_i, wb_en_i, wb_addr_i,
               br_taken_i,
        input  issue_o, stall_o, flush_o, pending_o, stall_cnt_o, err_o
    );

    modport slave (
        input  dec_valid_i, dec_r1_addr_i, dec_r1_used_i, dec_r2_addr_i,
               dec_r2_used_i, dec_rd_addr_i, dec_wr_i, wb_en_i, wb_addr_i,
               br_taken_i,
        output issue_o, stall_o, flush_o, pending_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Decode-stage issue/hazard controller. Tracks in-flight register writes in
//   a per-register counter scoreboard, stalls decode on RAW hazards (with
//   same-cycle write-back bypass), stalls when a destination counter is full,
//   runs the post-branch flush window and counts stall cycles.
// Ports
//   clk_i    : clock
//   reset_i  : asynchronous active-low reset
//   hif      : hazard_ctrl_if.slave
//              in : dec_* (decode instruction), wb_* (write-back), br_taken_i
//              out: issue_o/stall_o (comb), flush_o (registered state),
//                   pending_o, stall_cnt_o (saturating), err_o (sticky)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int NUM_REGS     = 16,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    hazard_ctrl_if.slave  hif
);
    localparam int              AW      = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CMAX    = '1;
    localparam logic [CNT_W-1:0] CONE    = CNT_W'(1);
    localparam logic [2:0]       FRELOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [2:0]          fcnt_q, fcnt_d;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [NUM_REGS-1:0] clr;     // write-back retiring a write to reg i
    logic [NUM_REGS-1:0] set;     // issuing instruction allocates reg i
    logic [NUM_REGS-1:0] busy;    // eff[i] != 0 (count after this cycle's wb)
    logic [NUM_REGS-1:0] wb_err;  // write-back to an idle register

    logic                haz, can_go, issue, stall, flush;
    logic                err_q;
    logic [15:0]         stall_cnt_q;

    // ---------------- scoreboard ----------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign clr[i]    = hif.wb_en_i && (hif.wb_addr_i == AW'(i));
        assign set[i]    = issue && hif.dec_wr_i && (hif.dec_rd_addr_i == AW'(i));
        // A write-back this cycle hides the last in-flight write (write-through RF).
        assign busy[i]   = (cnt_q[i] > CONE) || ((cnt_q[i] == CONE) && !clr[i]);
        assign wb_err[i] = clr[i] && (cnt_q[i] == '0);
        assign hif.pending_o[i] = (cnt_q[i] != '0);

        // No overflow: issue is blocked while cnt[rd] is at max.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i)
                cnt_q[i] <= '0;
            else if (set[i] && !clr[i])
                cnt_q[i] <= cnt_q[i] + CONE;
            else if (clr[i] && !set[i] && (cnt_q[i] != '0))
                cnt_q[i] <= cnt_q[i] - CONE;
        end
    end

    assign haz = (hif.dec_r1_used_i && busy[hif.dec_r1_addr_i])
               | (hif.dec_r2_used_i && busy[hif.dec_r2_addr_i])
               | (hif.dec_wr_i && (cnt_q[hif.dec_rd_addr_i] == CMAX));

    // ---------------- branch FSM: state register ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // ---------------- branch FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (hif.br_taken_i) begin
                    state_d = FLUSH;
                    fcnt_d  = FRELOAD;
                end
            end
            FLUSH: begin
                // A new taken branch restarts the window.
                if (hif.br_taken_i)
                    fcnt_d = FRELOAD;
                else if (fcnt_q == '0)
                    state_d = IDLE;
                else
                    fcnt_d = fcnt_q - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Nothing issues in the branch cycle or the flush window, so wrong-path
    // instructions never reach the scoreboard. Reset also blocks issue.
    always_comb begin
        can_go = reset_i && hif.dec_valid_i && (state_q == IDLE) && !hif.br_taken_i;
        issue  = can_go && !haz;
        stall  = can_go && haz;
        flush  = (state_q == FLUSH);
    end

    // ---------------- stall counter / error flag ----------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (|wb_err)
                err_q <= 1'b1;
        end
    end

    assign hif.issue_o     = issue;
    assign hif.stall_o     = stall;
    assign hif.flush_o     = flush;
    assign hif.stall_cnt_o = stall_cnt_q;
    assign hif.err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl (NUM_REGS=16, CNT_W=2, FLUSH_CYCLES=2).
//   Inputs change #1 after a rising edge; combinational outputs are checked
//   #1 later, registered outputs after the following edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    hazard_ctrl_if #(.NUM_REGS(16)) hif ();

    hazard_ctrl #(.NUM_REGS(16), .CNT_W(2), .FLUSH_CYCLES(2)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .hif     (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input logic v, input logic wr, input logic [3:0] rd,
                       input logic u1, input logic [3:0] r1,
                       input logic u2, input logic [3:0] r2);
        hif.dec_valid_i   = v;
        hif.dec_wr_i      = wr;
        hif.dec_rd_addr_i = rd;
        hif.dec_r1_used_i = u1;
        hif.dec_r1_addr_i = r1;
        hif.dec_r2_used_i = u2;
        hif.dec_r2_addr_i = r2;
    endtask

    task automatic wb(input logic en, input logic [3:0] addr);
        hif.wb_en_i   = en;
        hif.wb_addr_i = addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        hif.br_taken_i = 1'b0;
        dec(0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
        #2;
        chk("rst_pending", 32'(hif.pending_o), 0);
        chk("rst_issue",   32'(hif.issue_o), 0);
        chk("rst_stall",   32'(hif.stall_o), 0);
        chk("rst_flush",   32'(hif.flush_o), 0);
        chk("rst_scnt",    32'(hif.stall_cnt_o), 0);
        chk("rst_err",     32'(hif.err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: RAW on r3, resolved by same-cycle write-back
        dec(1, 1, 3, 0, 0, 0, 0); #1;
        chk("t1_issue_wr", 32'(hif.issue_o), 1);
        tick();
        dec(1, 0, 0, 1, 3, 0, 0); #1;
        chk("t1_stall_a", 32'(hif.stall_o), 1);
        chk("t1_noissue", 32'(hif.issue_o), 0);
        chk("t1_pend3",   32'(hif.pending_o), 32'h0008);
        tick();
        chk("t1_stall_b", 32'(hif.stall_o), 1);
        tick();
        chk("t1_scnt", 32'(hif.stall_cnt_o), 2);
        wb(1, 3); #1;
        chk("t1_byp_issue", 32'(hif.issue_o), 1);
        chk("t1_byp_stall", 32'(hif.stall_o), 0);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0); wb(0, 0); #1;
        chk("t1_pend_clr", 32'(hif.pending_o), 0);

        // 2: r5 counter saturates at 3
        dec(1, 1, 5, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t2_issue", 32'(hif.issue_o), 1);
            tick();
        end
        chk("t2_full_stall", 32'(hif.stall_o), 1);
        tick();
        wb(1, 5); #1;
        chk("t2_wb_cycle_stall", 32'(hif.stall_o), 1);
        tick();
        wb(0, 0); #1;
        chk("t2_4th_issue", 32'(hif.issue_o), 1);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0); #1;
        chk("t2_pend5", 32'(hif.pending_o), 32'h0020);
        chk("t2_scnt",  32'(hif.stall_cnt_o), 4);
        for (int k = 0; k < 3; k++) begin
            wb(1, 5);
            tick();
            wb(0, 0); #1;
            chk("t2_drain", 32'(hif.pending_o), (k < 2) ? 32'h0020 : 32'h0);
        end

        // 3: simultaneous set and clear on r2
        dec(1, 1, 2, 0, 0, 0, 0);
        tick();
        wb(1, 2); #1;
        chk("t3_issue", 32'(hif.issue_o), 1);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0); wb(0, 0); #1;
        chk("t3_pend2", 32'(hif.pending_o), 32'h0004);
        wb(1, 2);
        tick();
        wb(0, 0); #1;
        chk("t3_pend_clr", 32'(hif.pending_o), 0);
        chk("t3_err", 32'(hif.err_o), 0);

        // 4a: single taken branch
        dec(1, 0, 0, 0, 0, 0, 0);
        hif.br_taken_i = 1'b1; #1;
        chk("t4_T_issue", 32'(hif.issue_o), 0);
        chk("t4_T_stall", 32'(hif.stall_o), 0);
        chk("t4_T_flush", 32'(hif.flush_o), 0);
        tick();
        hif.br_taken_i = 1'b0; #1;
        chk("t4_T1_flush", 32'(hif.flush_o), 1);
        chk("t4_T1_issue", 32'(hif.issue_o), 0);
        tick();
        chk("t4_T2_flush", 32'(hif.flush_o), 1);
        tick();
        chk("t4_T3_flush", 32'(hif.flush_o), 0);
        chk("t4_T3_issue", 32'(hif.issue_o), 1);

        // 4b: window extension, write-back to r9 during flush
        dec(1, 1, 9, 0, 0, 0, 0);
        tick();
        dec(1, 0, 0, 0, 0, 0, 0);
        hif.br_taken_i = 1'b1;
        tick();
        wb(1, 9); #1;
        chk("t4b_T1_flush", 32'(hif.flush_o), 1);
        tick();
        hif.br_taken_i = 1'b0; wb(0, 0); #1;
        chk("t4b_T2_flush", 32'(hif.flush_o), 1);
        tick();
        chk("t4b_T3_flush", 32'(hif.flush_o), 1);
        tick();
        chk("t4b_T4_flush", 32'(hif.flush_o), 0);
        chk("t4b_pend9",    32'(hif.pending_o), 0);
        dec(0, 0, 0, 0, 0, 0, 0);

        // 5: spurious write-back to r7
        wb(1, 7);
        tick();
        wb(0, 0); #1;
        chk("t5_err",  32'(hif.err_o), 1);
        chk("t5_pend", 32'(hif.pending_o), 0);
        tick(); tick();
        chk("t5_err_sticky", 32'(hif.err_o), 1);
        dec(1, 1, 7, 0, 0, 0, 0);
        tick();
        dec(1, 0, 0, 0, 0, 1, 7); #1;
        chk("t5_stall_r2", 32'(hif.stall_o), 1);
        tick();
        wb(1, 7); #1;
        chk("t5_byp_issue", 32'(hif.issue_o), 1);
        tick();
        dec(0, 0, 0, 0, 0, 0, 0); wb(0, 0); #1;
        chk("t5_pend_clr", 32'(hif.pending_o), 0);
        chk("t5_scnt", 32'(hif.stall_cnt_o), 5);

        // 6: long stall saturates the counter, then async reset mid-stall
        dec(1, 1, 1, 0, 0, 0, 0);
        tick();
        dec(1, 0, 0, 1, 1, 0, 0);
        repeat (70000) tick();
        chk("t6_scnt_sat", 32'(hif.stall_cnt_o), 32'hFFFF);
        chk("t6_stall",    32'(hif.stall_o), 1);
        #2;
        rst_n = 1'b0; #1;
        chk("t6_rst_issue", 32'(hif.issue_o), 0);
        chk("t6_rst_stall", 32'(hif.stall_o), 0);
        chk("t6_rst_pend",  32'(hif.pending_o), 0);
        chk("t6_rst_scnt",  32'(hif.stall_cnt_o), 0);
        chk("t6_rst_err",   32'(hif.err_o), 0);
        chk("t6_rst_flush", 32'(hif.flush_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
